fir_addr_seq: RTL and testbench
===============================

// Module: fir_addr_seq
// PURPOSE
//  Address sequencer for the FIR datapath; sits directly upstream of the address
//  register stage and drives its ld strobe and 8-bit address inputs.
//  - On each new-sample request: writes the sample slot of a circular delay line.
//  - Then walks all taps, issuing paired sample/coefficient addresses plus
//    accumulator clear/enable.
//  - Signals done when the output sample is complete.
// PARAMETERS
//  ADDR_W  8    address width of x_addr / c_addr
//  TAPS    16   filter length; legal 2..2**(ADDR_W-1)
//  BASE_X  0    base address of sample delay line (TAPS words)
//  BASE_C  128  base address of coefficient table; BASE_X+TAPS <= BASE_C required
// PORTS
//  clk      in   1       rising-edge clock
//  rst      in   1       asynchronous, active-low reset
//  start    in   1       new sample ready; sampled only in IDLE
//  x_addr   out  ADDR_W  sample-memory address (to address register inAddress)
//  c_addr   out  ADDR_W  coefficient address
//  ld       out  1       load strobe for downstream address registers
//  mem_we   out  1       write enable for sample memory at x_addr
//  acc_clr  out  1       clear MAC accumulator
//  acc_en   out  1       MAC accumulate enable (aligned to registered address)
//  busy     out  1       high from WRITE through DONE
//  done     out  1       one-cycle pulse: output sample valid
// BEHAVIOUR
//  - Outputs and internal state are registered.
//  - rst=0: all outputs 0, state=IDLE, wr_ptr=0, k=0. Takes effect immediately,
//    including mid-operation. No done is issued for an aborted frame.
//  - FSM transitions:
//    IDLE  -> WRITE  when start=1; otherwise stay.
//    WRITE (1 cycle):   mem_we=1, ld=1, acc_clr=1, x_addr=BASE_X+wr_ptr; k<=0.
//    CALC  (TAPS cycles, k=0..TAPS-1): ld=1,
//          x_addr=BASE_X+((wr_ptr-k) mod TAPS), c_addr=BASE_C+k.
//          acc_en=1 from the 2nd CALC cycle on (one-cycle address-register latency).
//    FLUSH (1 cycle):   acc_en=1 for the last tap; ld=0.
//    DONE  (1 cycle):   done=1; wr_ptr <= (wr_ptr==TAPS-1) ? 0 : wr_ptr+1; -> IDLE.
//  - Outputs in states where they are not listed above: 0.
//    x_addr/c_addr hold their last value when ld=0.
//  - Latency: start sampled at edge 0 -> done high in cycle TAPS+3.
//    Throughput: one sample per TAPS+4 cycles.
//  - Modulo arithmetic uses explicit compare-and-wrap, not bit truncation, so
//    non-power-of-two TAPS is legal. (wr_ptr-k) wraps below 0 to TAPS-1.
//  - start while busy (including in DONE) is ignored and not queued.
//    start held high re-triggers from IDLE on the cycle after DONE.
//  - busy=1 exactly in WRITE, CALC, FLUSH, DONE.
// STRUCTURE
//  - fir_pkg: state encoding localparams
//    (S_IDLE, S_WRITE, S_CALC, S_FLUSH, S_DONE), default TAPS/BASE_X/BASE_C.
//    Shared with the datapath bench.
//  - Sub-module tap_counter: mod-TAPS up-counter with clr, en, count, last flag.
//    Instantiated for k and for wr_ptr. wr_ptr minus k is computed in top-level
//    combinational logic.
// TESTING (TAPS=4, BASE_X=0, BASE_C=128)
//  1. Reset: drive rst=0 mid-CALC -> all outputs 0 in the same cycle, no done;
//     next start writes x_addr=0.
//  2. First frame: start pulse ->
//     WRITE x_addr=0 with mem_we=1, acc_clr=1;
//     CALC x_addr=0,3,2,1 / c_addr=128,129,130,131;
//     acc_en high for 4 cycles; done at cycle 7.
//  3. Second frame: write x_addr=1; CALC x_addr=1,0,3,2; c_addr=128..131.
//  4. Wrap: after 4 frames wr_ptr returns to 0; 5th frame write x_addr=0.
//  5. start held high for 20 cycles -> frames back-to-back, done every 8 cycles,
//     no extra done, busy low exactly one cycle between frames.
//  6. TAPS=5 build: sequence after wr_ptr=2 is x_addr=2,1,0,4,3 -> checks
//     non-power-of-two wrap.

Source files
------------

// File: rtl/fir_addr_seq_pkg.sv
// Shared definitions for the FIR address sequencer: state encoding and default geometry.
// Also imported by the datapath bench so both agree on the memory map.
package fir_addr_seq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_TAPS   = 16;
    localparam int DEF_BASE_X = 0;
    localparam int DEF_BASE_C = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CALC,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/fir_addr_seq_if.sv
// Control/address bundle between the sequencer and the FIR address register stage.
// The slave side is the sequencer; the master side requests samples and consumes addresses.
interface fir_addr_seq_if
    import fir_addr_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] c_addr;
    logic              ld;
    logic              mem_we;
    logic              acc_clr;
    logic              acc_en;
    logic              busy;
    logic              done;

    modport master (
        output start,
        input  x_addr, c_addr, ld, mem_we, acc_clr, acc_en, busy, done
    );

    modport slave (
        input  start,
        output x_addr, c_addr, ld, mem_we, acc_clr, acc_en, busy, done
    );

endinterface

// File: rtl/fir_addr_seq_tap_counter.sv
// Modulo-MOD up-counter with synchronous clear and enable; wraps by compare, so MOD
// need not be a power of two.
module fir_addr_seq_tap_counter #(
    parameter int W   = 8,
    parameter int MOD = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST);

endmodule

// File: rtl/fir_addr_seq.sv
// FIR address sequencer: writes the new sample into a circular delay line, then walks
// every tap issuing paired sample/coefficient addresses with accumulator control.
module fir_addr_seq
    import fir_addr_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int BASE_X = DEF_BASE_X,
    parameter int BASE_C = DEF_BASE_C
)(
    input logic           clk,
    input logic           rst_n,
    fir_addr_seq_if.slave bus
);

    localparam logic [ADDR_W-1:0] BASE_X_A = ADDR_W'(BASE_X);
    localparam logic [ADDR_W-1:0] BASE_C_A = ADDR_W'(BASE_C);
    localparam logic [ADDR_W-1:0] TAPS_A   = ADDR_W'(TAPS);

    state_t            r_state;
    state_t            w_next_state;

    logic [ADDR_W-1:0] r_x_addr;
    logic [ADDR_W-1:0] r_c_addr;
    logic              r_ld;
    logic              r_mem_we;
    logic              r_acc_clr;
    logic              r_acc_en;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_x_addr;
    logic [ADDR_W-1:0] w_c_addr;
    logic              w_ld;
    logic              w_mem_we;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic              w_busy;
    logic              w_done;

    logic              w_k_clr;
    logic              w_k_en;
    logic              w_wp_en;
    logic [ADDR_W-1:0] w_k;
    logic              w_k_last;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic              w_unused_wp_last;
    logic [ADDR_W-1:0] w_k_issue;
    logic [ADDR_W-1:0] w_tap_x;

    fir_addr_seq_tap_counter #(.W(ADDR_W), .MOD(TAPS)) u_k_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_k_clr),
        .i_en    (w_k_en),
        .o_count (w_k),
        .o_last  (w_k_last)
    );

    fir_addr_seq_tap_counter #(.W(ADDR_W), .MOD(TAPS)) u_wp_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (1'b0),
        .i_en    (w_wp_en),
        .o_count (w_wr_ptr),
        .o_last  (w_unused_wp_last)
    );

    // k tracks the tap currently on the outputs; CALC therefore prepares tap k+1.
    assign w_k_issue = (r_state == S_CALC) ? w_k + 1'b1 : w_k;
    assign w_tap_x   = (w_wr_ptr >= w_k_issue) ? (w_wr_ptr - w_k_issue)
                                               : (w_wr_ptr + (TAPS_A - w_k_issue));

    always_comb begin
        w_next_state = r_state;
        w_x_addr     = r_x_addr;
        w_c_addr     = r_c_addr;
        w_ld         = 1'b0;
        w_mem_we     = 1'b0;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_k_clr      = 1'b0;
        w_k_en       = 1'b0;
        w_wp_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_k_clr = 1'b1;
                if (bus.start) begin
                    w_next_state = S_WRITE;
                    w_mem_we     = 1'b1;
                    w_ld         = 1'b1;
                    w_acc_clr    = 1'b1;
                    w_busy       = 1'b1;
                    w_x_addr     = BASE_X_A + w_wr_ptr;
                end
            end
            S_WRITE: begin
                w_next_state = S_CALC;
                w_ld         = 1'b1;
                w_busy       = 1'b1;
                w_x_addr     = BASE_X_A + w_tap_x;
                w_c_addr     = BASE_C_A + w_k_issue;
            end
            S_CALC: begin
                w_busy   = 1'b1;
                w_acc_en = 1'b1;
                if (w_k_last) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_k_en   = 1'b1;
                    w_ld     = 1'b1;
                    w_x_addr = BASE_X_A + w_tap_x;
                    w_c_addr = BASE_C_A + w_k_issue;
                end
            end
            S_FLUSH: begin
                w_next_state = S_DONE;
                w_busy       = 1'b1;
                w_done       = 1'b1;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_wp_en      = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x_addr  <= '0;
            r_c_addr  <= '0;
            r_ld      <= 1'b0;
            r_mem_we  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_acc_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_x_addr  <= w_x_addr;
            r_c_addr  <= w_c_addr;
            r_ld      <= w_ld;
            r_mem_we  <= w_mem_we;
            r_acc_clr <= w_acc_clr;
            r_acc_en  <= w_acc_en;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign bus.x_addr  = r_x_addr;
    assign bus.c_addr  = r_c_addr;
    assign bus.ld      = r_ld;
    assign bus.mem_we  = r_mem_we;
    assign bus.acc_clr = r_acc_clr;
    assign bus.acc_en  = r_acc_en;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_fir_addr_seq.sv
// Bench for fir_addr_seq: a TAPS=4 and a TAPS=5 instance checked cycle by cycle
// against per-frame expectations queued when each start is driven.
module tb_fir_addr_seq;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] c;
        logic       ld;
        logic       we;
        logic       clr;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   nCompared   = 0;
    int   nMismatched = 0;

    vec_t sbQ[$];
    int   mTaps[2] = '{4, 5};
    int   mWp[2]   = '{0, 0};
    int   mX[2]    = '{0, 0};
    int   mC[2]    = '{0, 0};

    fir_addr_seq_if #(.ADDR_W(8)) bus4 ();
    fir_addr_seq_if #(.ADDR_W(8)) bus5 ();

    fir_addr_seq #(.ADDR_W(8), .TAPS(4), .BASE_X(0), .BASE_C(128)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    fir_addr_seq #(.ADDR_W(8), .TAPS(5), .BASE_X(0), .BASE_C(128)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    vec_t obs4;
    vec_t obs5;
    assign obs4 = {bus4.x_addr, bus4.c_addr, bus4.ld, bus4.mem_we, bus4.acc_clr,
                   bus4.acc_en, bus4.busy, bus4.done};
    assign obs5 = {bus5.x_addr, bus5.c_addr, bus5.ld, bus5.mem_we, bus5.acc_clr,
                   bus5.acc_en, bus5.busy, bus5.done};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared=%0d", nCompared);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) bus4.start = v;
        else          bus5.start = v;
    endtask

    // One frame = WRITE, TAPS CALC cycles, FLUSH, DONE, then one IDLE cycle.
    function automatic void push_frame(input int sel);
        int   t  = mTaps[sel];
        int   wp = mWp[sel];
        vec_t v;
        v      = '0;
        v.x    = 8'(wp);
        v.c    = 8'(mC[sel]);
        v.ld   = 1'b1;
        v.we   = 1'b1;
        v.clr  = 1'b1;
        v.busy = 1'b1;
        sbQ.push_back(v);
        for (int k = 0; k < t; k++) begin
            v      = '0;
            v.x    = 8'((wp + t - k) % t);
            v.c    = 8'(128 + k);
            v.ld   = 1'b1;
            v.en   = (k != 0);
            v.busy = 1'b1;
            sbQ.push_back(v);
        end
        mX[sel]  = int'(v.x);
        mC[sel]  = int'(v.c);
        v.ld     = 1'b0;
        v.en     = 1'b1;
        sbQ.push_back(v);
        v.en     = 1'b0;
        v.done   = 1'b1;
        sbQ.push_back(v);
        v.done   = 1'b0;
        v.busy   = 1'b0;
        sbQ.push_back(v);
        mWp[sel] = (wp + 1) % t;
    endfunction

    function automatic void push_idle(input int sel, input int n);
        vec_t v;
        v   = '0;
        v.x = 8'(mX[sel]);
        v.c = 8'(mC[sel]);
        for (int i = 0; i < n; i++) sbQ.push_back(v);
    endfunction

    task automatic pop_expected(output vec_t e, output bit ok);
        if (sbQ.size() == 0) begin
            e  = '0;
            ok = 1'b0;
        end else begin
            e  = sbQ.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        vec_t zero = '0;
        rst_n = 1'b0;
        set_start(0, 1'b1);
        set_start(1, 1'b1);
        repeat (2) @(negedge clk);
        nCompared++;
        if (obs4 !== zero) begin
            nMismatched++;
            $display("FAIL reset_t4: got %h required %h", obs4, zero);
        end
        nCompared++;
        if (obs5 !== zero) begin
            nMismatched++;
            $display("FAIL reset_t5: got %h required %h", obs5, zero);
        end
        set_start(0, 1'b0);
        set_start(1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frames(input string tag, input int nFrames);
        vec_t exp;
        bit   ok;
        for (int f = 0; f < nFrames; f++) begin
            @(negedge clk);
            set_start(0, 1'b1);
            push_frame(0);
            for (int i = 1; i <= mTaps[0] + 4; i++) begin
                @(negedge clk);
                set_start(0, 1'b0);
                pop_expected(exp, ok);
                nCompared++;
                if (!ok || obs4 !== exp) begin
                    nMismatched++;
                    $display("FAIL %s f%0d c%0d: got %h required %h queued=%0b",
                             tag, f, i, obs4, exp, ok);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        vec_t exp;
        vec_t zero = '0;
        bit   ok;
        @(negedge clk);
        set_start(0, 1'b1);
        push_frame(0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            set_start(0, 1'b0);
            pop_expected(exp, ok);
            nCompared++;
            if (!ok || obs4 !== exp) begin
                nMismatched++;
                $display("FAIL pre_abort c%0d: got %h required %h queued=%0b", i, obs4, exp, ok);
            end
        end
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (obs4 !== zero) begin
            nMismatched++;
            $display("FAIL abort_same_cycle: got %h required %h", obs4, zero);
        end
        sbQ.delete();
        mWp = '{0, 0};
        mX  = '{0, 0};
        mC  = '{0, 0};
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            nCompared++;
            if (obs4 !== zero) begin
                nMismatched++;
                $display("FAIL abort_hold c%0d: got %h required %h", i, obs4, zero);
            end
        end
        rst_n = 1'b1;
        push_idle(0, 2);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            pop_expected(exp, ok);
            nCompared++;
            if (!ok || obs4 !== exp) begin
                nMismatched++;
                $display("FAIL post_abort_idle c%0d: got %h required %h queued=%0b", i, obs4, exp, ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t exp;
        bit   ok;
        @(negedge clk);
        set_start(0, 1'b1);
        push_frame(0);
        push_frame(0);
        push_frame(0);
        push_idle(0, 4);
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            if (i >= 20) set_start(0, 1'b0);
            pop_expected(exp, ok);
            nCompared++;
            if (!ok || obs4 !== exp) begin
                nMismatched++;
                $display("FAIL back_to_back c%0d: got %h required %h queued=%0b", i, obs4, exp, ok);
            end
        end
    endtask

    task automatic test_taps5();
        vec_t exp;
        bit   ok;
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            set_start(1, 1'b1);
            push_frame(1);
            for (int i = 1; i <= mTaps[1] + 4; i++) begin
                @(negedge clk);
                set_start(1, 1'b0);
                pop_expected(exp, ok);
                nCompared++;
                if (!ok || obs5 !== exp) begin
                    nMismatched++;
                    $display("FAIL taps5 f%0d c%0d: got %h required %h queued=%0b",
                             f, i, obs5, exp, ok);
                end
            end
        end
    endtask

    initial begin
        bus4.start = 1'b0;
        bus5.start = 1'b0;
        $display("[TB] start");
        test_reset();
        test_frames("first_frame", 1);
        test_frames("second_frame", 1);
        test_mid_reset();
        test_frames("wrap", 5);
        test_back_to_back();
        test_taps5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
